// File: rtl/rgmii_phy_mgmt.sv
// rgmii_phy_mgmt: PHY hardware-reset sequencer and clause-22 MDIO read/write master.
// Define RGMII_PHY_MGMT_IRQ_EN to enable the sticky PHY interrupt flag.
module rgmii_phy_mgmt #(
  parameter int CLK_DIV         = 25,
  parameter int RST_CYCLES      = 1250000,
  parameter int RST_WAIT_CYCLES = 625000
) (
  input  logic        clk_int,
  input  logic        rst_int,
  input  logic        soft_reset,
  output logic        phy_ready,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        phy_reset_n,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  input  logic        phy_int_n,
  input  logic        irq_clr,
  output logic        irq
);
  localparam logic [2:0] ST_RST_ASSERT = 3'd0;
  localparam logic [2:0] ST_RST_WAIT   = 3'd1;
  localparam logic [2:0] ST_IDLE       = 3'd2;
  localparam logic [2:0] ST_FRAME      = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;
  localparam int MAX_RW = RST_CYCLES > RST_WAIT_CYCLES ? RST_CYCLES : RST_WAIT_CYCLES;
  localparam int MAXC   = MAX_RW > CLK_DIV ? MAX_RW : CLK_DIV;
  localparam int CW     = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic [5:0]    bit_q, bit_d;
  logic [63:0]   sr_q, sr_d;
  logic          wr_q, wr_d;
  logic [15:0]   rd_q, rd_d;
  logic          ta_q, ta_d;
  logic [1:0]    mdi_q, mdi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  assign cmd_ready   = (state_q == ST_IDLE) & ~soft_reset;
  assign phy_reset_n = state_q != ST_RST_ASSERT;
  assign phy_ready   = (state_q == ST_IDLE) | (state_q == ST_FRAME) | (state_q == ST_DONE);
  assign mdc         = mdc_q;
  assign mdio_o      = sr_q[63];
  // On reads the bus is released from the first turnaround bit to the end of data.
  assign mdio_oe     = (state_q == ST_FRAME) & (wr_q | (bit_q < 6'd46));
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    mdc_d       = mdc_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    ta_d        = ta_q;
    mdi_d       = {mdi_q[0], mdio_i};
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_RST_ASSERT: if (cnt_q == RST_LAST) begin
        state_d = ST_RST_WAIT;
        cnt_d   = '0;
      end
      ST_RST_WAIT: if (cnt_q == WAIT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d = ST_FRAME;
          wr_d    = cmd_write;
          bit_d   = '0;
          sr_d    = {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                     cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};
        end
      end
      ST_FRAME: if (cnt_q == DIV_LAST) begin
        cnt_d = '0;
        mdc_d = ~mdc_q;
        // Falling MDC edge: sample the bit from the high phase and present the next one.
        if (mdc_q) begin
          sr_d  = {sr_q[62:0], 1'b1};
          rd_d  = {rd_q[14:0], mdi_q[1]};
          ta_d  = bit_q == 6'd47 ? mdi_q[1] : ta_q;
          bit_d = bit_q + 6'd1;
          state_d = bit_q == 6'd63 ? ST_DONE : ST_FRAME;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = wr_q ? 16'h0000 : rd_q;
        rsp_err_d   = ~wr_q & ta_q;
      end
      default: begin
        state_d = ST_RST_ASSERT;
        cnt_d   = '0;
      end
    endcase
    if (soft_reset) begin
      state_d     = ST_RST_ASSERT;
      cnt_d       = '0;
      mdc_d       = 1'b0;
      sr_d        = '1;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_int or posedge rst_int)
    if (rst_int) begin
      state_q     <= ST_RST_ASSERT;
      cnt_q       <= '0;
      mdc_q       <= 1'b0;
      bit_q       <= '0;
      sr_q        <= '1;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      ta_q        <= 1'b0;
      mdi_q       <= 2'b11;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdc_q       <= mdc_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ta_q        <= ta_d;
      mdi_q       <= mdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end

`ifdef RGMII_PHY_MGMT_IRQ_EN
  logic [1:0] int_q, int_d;
  logic       irq_q, irq_d;

  always_comb begin
    int_d = {int_q[0], phy_int_n};
    irq_d = ~phy_ready ? 1'b0 : ~int_q[1] ? 1'b1 : irq_clr ? 1'b0 : irq_q;
  end

  always_ff @(posedge clk_int or posedge rst_int)
    if (rst_int) begin
      int_q <= 2'b11;
      irq_q <= 1'b0;
    end else begin
      int_q <= int_d;
      irq_q <= irq_d;
    end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = phy_int_n ^ irq_clr;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_rgmii_phy_mgmt.sv
// tb_rgmii_phy_mgmt: directed bench for rgmii_phy_mgmt with a small MDIO PHY model.
module tb_rgmii_phy_mgmt;
  logic        clk_int = 1'b0, rst_int = 1'b1, soft_reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_i, phy_int_n = 1'b1, irq_clr = 1'b0;
  logic        phy_ready, cmd_ready, rsp_valid, rsp_err, phy_reset_n, mdc, mdio_o, mdio_oe, irq;
  logic [15:0] rsp_rdata;
  int          n_vec = 0, n_err = 0;

  always #5 clk_int = ~clk_int;

  rgmii_phy_mgmt #(.CLK_DIV(2), .RST_CYCLES(10), .RST_WAIT_CYCLES(20)) dut (
    .clk_int(clk_int), .rst_int(rst_int), .soft_reset(soft_reset), .phy_ready(phy_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .phy_reset_n(phy_reset_n), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .mdio_i(mdio_i), .phy_int_n(phy_int_n), .irq_clr(irq_clr), .irq(irq)
  );

  logic [63:0] stream = '0, oe_s = '0, phy_bits = '1, ph_sh;
  int          nrise = 0, nfall = 0, fbase = 0, rbase = 0;
  logic        phy_present = 1'b0;

  always @(posedge mdc) begin
    #1;
    stream = {stream[62:0], mdio_o};
    oe_s   = {oe_s[62:0], mdio_oe};
    nrise++;
  end

  always @(negedge mdc) begin
    #1;
    nfall++;
  end

  // PHY model presents frame bit n after the n-th falling MDC edge of the current frame.
  assign ph_sh  = phy_bits << (nfall - fbase);
  assign mdio_i = ~phy_present | ph_sh[63];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic run_cmd(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input logic present, input logic [15:0] model,
                         output int lat);
    phy_bits     = {{46{1'b1}}, 2'b10, model};
    phy_present  = present;
    fbase        = nfall;
    rbase        = nrise;
    cmd_write    = wr;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata    = wd;
    cmd_valid    = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (i == 1) chk("mdc_before_rise", mdc, 1'b0);
      if (i == 2) chk("mdc_first_rise", mdc, 1'b1);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  int  lat, seen, nr0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_phy_reset_n", phy_reset_n, 1'b0);
    chk("rst_mdc", mdc, 1'b0);
    chk("rst_mdio_o", mdio_o, 1'b1);
    chk("rst_mdio_oe", mdio_oe, 1'b0);
    chk("rst_phy_ready", phy_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    rst_int = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("seq_phy_reset_n", phy_reset_n, i >= 10);
      chk("seq_phy_ready", phy_ready, i >= 30);
      chk("seq_cmd_ready", cmd_ready, i >= 30);
    end

    run_cmd(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0, lat);
    chk("wr_latency", lat, 257);
    chk("wr_rdata", rsp_rdata, 16'h0);
    chk("wr_err", rsp_err, 1'b0);
    chk("wr_stream", stream, {32'hFFFF_FFFF, 4'b0101, 5'd1, 5'd0, 2'b10, 16'h1140});
    chk("wr_oe", oe_s, {64{1'b1}});
    chk("wr_bits", nrise - rbase, 64);
    tick();
    chk("wr_pulse_len", rsp_valid, 1'b0);
    chk("wr_done_oe", mdio_oe, 1'b0);
    chk("wr_done_mdc", mdc, 1'b0);

    run_cmd(1'b0, 5'h03, 5'h02, 16'h0, 1'b1, 16'h1234, lat);
    chk("rd_latency", lat, 257);
    chk("rd_rdata", rsp_rdata, 16'h1234);
    chk("rd_err", rsp_err, 1'b0);
    chk("rd_stream_hdr", stream[63:18], {32'hFFFF_FFFF, 4'b0110, 5'd3, 5'd2});
    chk("rd_oe", oe_s, {{46{1'b1}}, 18'h0});

    run_cmd(1'b0, 5'h05, 5'h01, 16'h0, 1'b0, 16'h0, lat);
    chk("nophy_latency", lat, 257);
    chk("nophy_rdata", rsp_rdata, 16'hFFFF);
    chk("nophy_err", rsp_err, 1'b1);
    repeat (4) tick();
    chk("nophy_err_held", rsp_err, 1'b1);
    chk("nophy_rdata_held", rsp_rdata, 16'hFFFF);

    phy_present = 1'b0;
    rbase = nrise;
    cmd_write = 1'b1;
    cmd_wdata = 16'hA5A5;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && (nrise - rbase) < 41; i++) tick();
    chk("sr_reach_bit40", nrise - rbase, 41);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk("sr_mdio_oe", mdio_oe, 1'b0);
    chk("sr_phy_reset_n", phy_reset_n, 1'b0);
    chk("sr_mdc", mdc, 1'b0);
    chk("sr_phy_ready", phy_ready, 1'b0);
    seen = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rsp_valid) seen = 1;
      chk("sr_seq_phy_reset_n", phy_reset_n, i >= 10);
      chk("sr_seq_phy_ready", phy_ready, i >= 30);
    end
    chk("sr_no_rsp", seen, 0);
    run_cmd(1'b0, 5'h01, 5'h02, 16'h0, 1'b1, 16'hBEEF, lat);
    chk("sr_rd_latency", lat, 257);
    chk("sr_rd_rdata", rsp_rdata, 16'hBEEF);
    chk("sr_rd_err", rsp_err, 1'b0);
    tick();

    nr0 = nrise;
    cmd_valid = 1'b1;
    soft_reset = 1'b1;
    #1;
    chk("coinc_cmd_ready", cmd_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    soft_reset = 1'b0;
    chk("coinc_phy_reset_n", phy_reset_n, 1'b0);
    chk("coinc_phy_ready", phy_ready, 1'b0);
    repeat (30) tick();
    chk("coinc_ready_back", phy_ready, 1'b1);
    chk("coinc_no_frame", nrise - nr0, 0);

    phy_int_n = 1'b0;
    tick();
    phy_int_n = 1'b1;
    tick();
    tick();
`ifdef RGMII_PHY_MGMT_IRQ_EN
    chk("irq_set", irq, 1'b1);
    repeat (5) tick();
    chk("irq_sticky", irq, 1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_clear", irq, 1'b0);
    tick();
    chk("irq_stay_clear", irq, 1'b0);
`else
    chk("irq_off", irq, 1'b0);
    repeat (5) tick();
    chk("irq_off_later", irq, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
